// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
// Scan-code constants are for the downstream game state machine.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        CHECK = 2'd2
    } ps2_state_t;

    localparam int FRAME_BITS = 11;

    localparam logic [7:0] BREAK     = 8'hF0;
    localparam logic [7:0] EXTEND    = 8'hE0;
    localparam logic [7:0] KEY_LEFT  = 8'h6B;
    localparam logic [7:0] KEY_RIGHT = 8'h74;
    localparam logic [7:0] KEY_UP    = 8'h75;
    localparam logic [7:0] KEY_DOWN  = 8'h72;

endpackage

// File: rtl/ps2_sync_edge.sv
// Brings ps2_clk/ps2_data into the system clock domain and flags ps2_clk falling edges.
// Everything resets to the idle bus level (1), so no false edge appears when reset is released.
module ps2_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_ps2_clk,
    input  logic i_ps2_data,
    output logic o_fall,
    output logic o_data,
    output logic o_clk_lvl
);

    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_data_sync;
    logic                   r_clk_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_sync  <= '1;
            r_data_sync <= '1;
            r_clk_prev  <= 1'b1;
        end else begin
            r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], i_ps2_clk};
            r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], i_ps2_data};
            r_clk_prev  <= r_clk_sync[SYNC_STAGES-1];
        end
    end

    assign o_clk_lvl = r_clk_sync[SYNC_STAGES-1];
    assign o_data    = r_data_sync[SYNC_STAGES-1];
    assign o_fall    = r_clk_prev & ~r_clk_sync[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: deserialises 11-bit frames and presents the last two
// valid bytes on xkey, with one-cycle rdy / frame_err pulses.
module ps2_keyboard_rx
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 60000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [15:0] xkey,
    output logic [7:0]  byte_out,
    output logic        rdy,
    output logic        frame_err
);

    localparam int                SR_W     = FRAME_BITS - 1;
    localparam int                TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]     TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]        LAST_BIT = 4'(FRAME_BITS - 2);

    ps2_state_t      r_state;
    ps2_state_t      w_state_nxt;
    logic [3:0]      r_cnt;
    logic [SR_W-1:0] r_sr;
    logic [TW-1:0]   r_tmo;
    logic [15:0]     r_xkey;
    logic [7:0]      r_byte;
    logic            r_rdy;
    logic            r_ferr;

    logic w_fall;
    logic w_data;
    logic w_clk_lvl;
    logic w_edge;
    logic w_tmo_hit;
    logic w_valid;

    ps2_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk        (clk),
        .rst        (rst),
        .i_ps2_clk  (ps2_clk),
        .i_ps2_data (ps2_data),
        .o_fall     (w_fall),
        .o_data     (w_data),
        .o_clk_lvl  (w_clk_lvl)
    );

    assign w_edge    = w_fall & ~w_clk_lvl;
    assign w_tmo_hit = (r_tmo == TMO_LAST);
    // r_sr holds {stop, parity, d7..d0}; odd parity means the 9 bits XOR to 1
    assign w_valid   = (^r_sr[SR_W-2:0]) & r_sr[SR_W-1];

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:  if (w_edge && !w_data) w_state_nxt = RECV;
            RECV: begin
                if (w_edge) begin
                    if (r_cnt == LAST_BIT) w_state_nxt = CHECK;
                end else if (w_tmo_hit) begin
                    w_state_nxt = IDLE;
                end
            end
            CHECK:   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_sr   <= '0;
            r_tmo  <= '0;
            r_xkey <= '0;
            r_byte <= '0;
            r_rdy  <= 1'b0;
            r_ferr <= 1'b0;
        end else begin
            r_rdy  <= 1'b0;
            r_ferr <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_edge && !w_data) begin
                        r_cnt <= '0;
                        r_tmo <= '0;
                    end
                end
                RECV: begin
                    if (w_edge) begin
                        r_sr  <= {w_data, r_sr[SR_W-1:1]};
                        r_cnt <= r_cnt + 4'd1;
                        r_tmo <= '0;
                    end else if (w_tmo_hit) begin
                        r_ferr <= 1'b1;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                CHECK: begin
                    if (w_valid) begin
                        r_byte <= r_sr[7:0];
                        r_xkey <= {r_xkey[7:0], r_sr[7:0]};
                        r_rdy  <= 1'b1;
                    end else begin
                        r_ferr <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign xkey      = r_xkey;
    assign byte_out  = r_byte;
    assign rdy       = r_rdy;
    assign frame_err = r_ferr;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed bench for ps2_keyboard_rx with a scaled-down PS/2 bit period and timeout.
module tb_ps2_keyboard_rx;

    localparam int TO   = 400;
    localparam int SYNC = 2;
    localparam int HALF = 25;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [15:0] xkey;
    logic [7:0]  byte_out;
    logic        rdy;
    logic        frame_err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int rdy_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    int last_rdy_cyc = 0;
    int stop_fall_cyc = 0;

    ps2_keyboard_rx #(
        .TIMEOUT_CYCLES (TO),
        .SYNC_STAGES    (SYNC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .xkey      (xkey),
        .byte_out  (byte_out),
        .rdy       (rdy),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (rdy) begin
                rdy_cnt++;
                last_rdy_cyc = cyc;
            end
            if (frame_err) err_cnt++;
            if (rdy && frame_err) both_cnt++;
        end
    end

    function automatic logic [10:0] make_frame(input logic [7:0] d, input logic flip_par);
        return {1'b1, (~^d) ^ flip_par, d, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] f, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            ps2_data = f[i];
            repeat (HALF / 2) @(negedge clk);
            ps2_clk = 1'b0;
            if (i == 10) stop_fall_cyc = cyc;
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
            repeat (HALF - HALF / 2) @(negedge clk);
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic flip_par);
        send_bits(make_frame(d, flip_par), 11);
        repeat (100) @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        int anomalies;
        apply_reset();
        total++;
        if (xkey !== 16'h0000) begin bad++; $display("FAIL reset_xkey got=%h exp=0000", xkey); end
        total++;
        if (byte_out !== 8'h00) begin bad++; $display("FAIL reset_byte got=%h exp=00", byte_out); end
        total++;
        if (rdy !== 1'b0 || frame_err !== 1'b0)
            begin bad++; $display("FAIL reset_pulses got rdy=%b err=%b exp=0 0", rdy, frame_err); end
        anomalies = 0;
        repeat (1000) begin
            @(negedge clk);
            if (xkey !== 16'h0000 || rdy !== 1'b0 || frame_err !== 1'b0) anomalies++;
        end
        total++;
        if (anomalies != 0) begin bad++; $display("FAIL idle_quiet got=%0d bad cycles exp=0", anomalies); end
    endtask

    task automatic test_single_frame();
        int r0, e0;
        r0 = rdy_cnt; e0 = err_cnt;
        send_frame(8'h6B, 1'b0);
        total++;
        if (rdy_cnt - r0 != 1) begin bad++; $display("FAIL single_rdy got=%0d exp=1", rdy_cnt - r0); end
        total++;
        if (err_cnt - e0 != 0) begin bad++; $display("FAIL single_err got=%0d exp=0", err_cnt - e0); end
        total++;
        if (byte_out !== 8'h6B) begin bad++; $display("FAIL single_byte got=%h exp=6b", byte_out); end
        total++;
        if (xkey !== 16'h006B) begin bad++; $display("FAIL single_xkey got=%h exp=006b", xkey); end
        total++;
        if (last_rdy_cyc - stop_fall_cyc != SYNC + 2)
            begin bad++; $display("FAIL latency got=%0d exp=%0d", last_rdy_cyc - stop_fall_cyc, SYNC + 2); end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  seq [4];
        logic [15:0] exp_x [4];
        int r0;
        seq   = '{8'h6B, 8'h6B, 8'hF0, 8'h6B};
        exp_x = '{16'h006B, 16'h6B6B, 16'h6BF0, 16'hF06B};
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            r0 = rdy_cnt;
            send_frame(seq[i], 1'b0);
            total++;
            if (rdy_cnt - r0 != 1 || xkey !== exp_x[i])
                begin bad++; $display("FAIL b2b_%0d got rdy=%0d xkey=%h exp rdy=1 xkey=%h", i, rdy_cnt - r0, xkey, exp_x[i]); end
        end
    endtask

    task automatic test_parity_err();
        int r0, e0;
        r0 = rdy_cnt; e0 = err_cnt;
        send_frame(8'h75, 1'b1);
        total++;
        if (err_cnt - e0 != 1 || rdy_cnt - r0 != 0)
            begin bad++; $display("FAIL parity_pulses got err=%0d rdy=%0d exp 1 0", err_cnt - e0, rdy_cnt - r0); end
        total++;
        if (xkey !== 16'hF06B) begin bad++; $display("FAIL parity_hold got=%h exp=f06b", xkey); end
        r0 = rdy_cnt;
        send_frame(8'h72, 1'b0);
        total++;
        if (rdy_cnt - r0 != 1 || xkey !== 16'h6B72)
            begin bad++; $display("FAIL after_parity got rdy=%0d xkey=%h exp 1 6b72", rdy_cnt - r0, xkey); end
    endtask

    task automatic test_timeout();
        int r0, e0;
        r0 = rdy_cnt; e0 = err_cnt;
        send_bits(make_frame(8'h74, 1'b0), 5);
        repeat (TO + 50) @(negedge clk);
        total++;
        if (err_cnt - e0 != 1 || rdy_cnt - r0 != 0)
            begin bad++; $display("FAIL timeout_pulses got err=%0d rdy=%0d exp 1 0", err_cnt - e0, rdy_cnt - r0); end
        r0 = rdy_cnt;
        send_frame(8'h74, 1'b0);
        total++;
        if (rdy_cnt - r0 != 1 || byte_out !== 8'h74 || xkey !== 16'h7274)
            begin bad++; $display("FAIL after_timeout got rdy=%0d byte=%h xkey=%h exp 1 74 7274", rdy_cnt - r0, byte_out, xkey); end
    endtask

    task automatic test_reset_midframe();
        int r0, e0;
        send_bits(make_frame(8'h75, 1'b0), 6);
        apply_reset();
        r0 = rdy_cnt; e0 = err_cnt;
        send_frame(8'h75, 1'b0);
        total++;
        if (err_cnt - e0 != 0 || rdy_cnt - r0 != 1)
            begin bad++; $display("FAIL midreset_pulses got err=%0d rdy=%0d exp 0 1", err_cnt - e0, rdy_cnt - r0); end
        total++;
        if (xkey !== 16'h0075) begin bad++; $display("FAIL midreset_xkey got=%h exp=0075", xkey); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_parity_err();
        test_timeout();
        test_reset_midframe();
        total++;
        if (both_cnt != 0) begin bad++; $display("FAIL rdy_err_overlap got=%0d exp=0", both_cnt); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
